// File: rtl/cfs_algn_pkg.sv
// Shared types and helpers for the MD aligner: width derivation, transfer
// legality rule and the RX/TX controller state encodings.
package cfs_algn_pkg;

  typedef enum logic {
    RX_IDLE,
    RX_RESP
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_BUSY,
    TX_GAP
  } tx_state_t;

  function automatic int algn_offset_width(input int w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

  function automatic int algn_size_width(input int w);
    return $clog2(w) + 1;
  endfunction

  function automatic int algn_lvl_width(input int buf_bytes);
    return $clog2(buf_bytes) + 1;
  endfunction

  // A transfer must be non-empty, fit in the bus and sit on a size-aligned lane.
  function automatic logic algn_legal(input int offset, input int size, input int w);
    if (size == 0) return 1'b0;
    return ((offset + size) <= w) && (((w + offset) % size) == 0);
  endfunction

endpackage

// File: rtl/cfs_algn_byte_buf.sv
// Circular byte buffer with variable-length push and pop (up to W bytes each)
// and a W-byte read window starting at the read pointer.
module cfs_algn_byte_buf
  import cfs_algn_pkg::*;
#(
  parameter int W         = 4,
  parameter int BUF_BYTES = 16,
  localparam int SW = algn_size_width(W),
  localparam int LW = algn_lvl_width(BUF_BYTES)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            push_en_i,
  input  logic [SW-1:0]   push_cnt_i,
  input  logic [8*W-1:0]  push_data_i,
  input  logic            pop_en_i,
  input  logic [SW-1:0]   pop_cnt_i,
  output logic [LW-1:0]   lvl_o,
  output logic [8*W-1:0]  rd_bytes_o
);

  localparam int PW = LW - 1;

  logic [7:0]    mem_q [BUF_BYTES];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [LW-1:0] lvl_q;
  logic [SW-1:0] push_amt;
  logic [SW-1:0] pop_amt;

  assign push_amt = push_en_i ? push_cnt_i : '0;
  assign pop_amt  = pop_en_i  ? pop_cnt_i  : '0;
  assign lvl_o    = lvl_q;

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < W; i++) begin
      if (SW'(i) < push_amt) mem_q[wr_ptr_q + PW'(i)] <= push_data_i[8*i +: 8];
    end
  end

  // Pointer width is log2(BUF_BYTES), so plain addition wraps the ring.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      lvl_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + PW'(push_amt);
      rd_ptr_q <= rd_ptr_q + PW'(pop_amt);
      lvl_q    <= lvl_q + LW'(push_amt) - LW'(pop_amt);
    end
  end

  always_comb begin
    rd_bytes_o = '0;
    for (int unsigned i = 0; i < W; i++) begin
      rd_bytes_o[8*i +: 8] = mem_q[rd_ptr_q + PW'(i)];
    end
  end

endmodule

// File: rtl/cfs_md_aligner_engine.sv
// MD aligner: packs legal RX bytes into a ring buffer and re-emits them as
// TX transfers of the configured size/offset, with flush and error counters.
module cfs_md_aligner_engine
  import cfs_algn_pkg::*;
#(
  parameter int ALGN_DATA_WIDTH = 32,
  parameter int BUF_BYTES       = 16,
  localparam int W            = ALGN_DATA_WIDTH / 8,
  localparam int OFFSET_WIDTH = algn_offset_width(W),
  localparam int SIZE_WIDTH   = algn_size_width(W),
  localparam int LVL_WIDTH    = algn_lvl_width(BUF_BYTES)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       md_rx_valid,
  input  logic [ALGN_DATA_WIDTH-1:0] md_rx_data,
  input  logic [OFFSET_WIDTH-1:0]    md_rx_offset,
  input  logic [SIZE_WIDTH-1:0]      md_rx_size,
  output logic                       md_rx_ready,
  output logic                       md_rx_err,
  output logic                       md_tx_valid,
  output logic [ALGN_DATA_WIDTH-1:0] md_tx_data,
  output logic [OFFSET_WIDTH-1:0]    md_tx_offset,
  output logic [SIZE_WIDTH-1:0]      md_tx_size,
  input  logic                       md_tx_ready,
  input  logic                       md_tx_err,
  input  logic [OFFSET_WIDTH-1:0]    ctrl_offset,
  input  logic [SIZE_WIDTH-1:0]      ctrl_size,
  input  logic                       flush,
  input  logic                       clr_cnt,
  output logic                       cfg_err,
  output logic [LVL_WIDTH-1:0]       status_lvl,
  output logic [7:0]                 status_cnt_drop,
  output logic [7:0]                 status_cnt_tx_err,
  output logic                       irq_drop
);

  rx_state_t rx_state_q;
  tx_state_t tx_state_q;
  logic      flush_pend_q;

  logic                       rx_legal;
  logic                       rx_fits;
  logic                       rx_accept;
  logic                       push_en;
  logic [ALGN_DATA_WIDTH-1:0] push_data;
  logic                       pop_en;
  logic [LVL_WIDTH-1:0]       buf_lvl;
  logic [ALGN_DATA_WIDTH-1:0] rd_bytes;

  logic                       tx_full;
  logic                       tx_tail;
  logic                       tx_start;
  logic                       tx_tail_start;
  logic [SIZE_WIDTH-1:0]      tx_start_size;
  logic [OFFSET_WIDTH-1:0]    tx_start_off;
  logic [ALGN_DATA_WIDTH-1:0] tx_masked;
  logic [ALGN_DATA_WIDTH-1:0] tx_start_data;

  assign cfg_err    = !algn_legal(32'(ctrl_offset), 32'(ctrl_size), W);
  assign status_lvl = buf_lvl;

  // Space check uses the pre-pop level, so a same-cycle TX pop never helps.
  assign rx_legal  = algn_legal(32'(md_rx_offset), 32'(md_rx_size), W);
  assign rx_fits   = (LVL_WIDTH'(BUF_BYTES) - buf_lvl) >= LVL_WIDTH'(md_rx_size);
  assign rx_accept = (rx_state_q == RX_IDLE) && md_rx_valid && (!rx_legal || rx_fits);
  assign push_en   = rx_accept && rx_legal;
  assign push_data = md_rx_data >> {md_rx_offset, 3'b000};
  assign pop_en    = (tx_state_q == TX_BUSY) && md_tx_ready;

  cfs_algn_byte_buf #(
    .W         (W),
    .BUF_BYTES (BUF_BYTES)
  ) u_buf (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_en_i   (push_en),
    .push_cnt_i  (md_rx_size),
    .push_data_i (push_data),
    .pop_en_i    (pop_en),
    .pop_cnt_i   (md_tx_size),
    .lvl_o       (buf_lvl),
    .rd_bytes_o  (rd_bytes)
  );

  assign tx_full       = buf_lvl >= LVL_WIDTH'(ctrl_size);
  assign tx_tail       = flush_pend_q && (buf_lvl != '0);
  assign tx_start      = (tx_state_q == TX_IDLE) && !cfg_err && (tx_full || tx_tail);
  assign tx_tail_start = tx_start && !tx_full;

  // A tail is always shorter than ctrl_size, hence fits in SIZE_WIDTH.
  always_comb begin
    tx_start_size = tx_full ? ctrl_size : SIZE_WIDTH'(buf_lvl);
    tx_start_off  = tx_full ? ctrl_offset : '0;
    tx_masked     = '0;
    for (int unsigned i = 0; i < W; i++) begin
      if (SIZE_WIDTH'(i) < tx_start_size) tx_masked[8*i +: 8] = rd_bytes[8*i +: 8];
    end
    tx_start_data = tx_masked << {tx_start_off, 3'b000};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state_q      <= RX_IDLE;
      md_rx_ready     <= 1'b0;
      md_rx_err       <= 1'b0;
      irq_drop        <= 1'b0;
      status_cnt_drop <= '0;
    end else begin
      md_rx_ready <= 1'b0;
      md_rx_err   <= 1'b0;
      irq_drop    <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          if (rx_accept) begin
            rx_state_q  <= RX_RESP;
            md_rx_ready <= 1'b1;
            md_rx_err   <= !rx_legal;
            irq_drop    <= !rx_legal;
          end
        end
        RX_RESP: rx_state_q <= RX_IDLE;
      endcase
      if (clr_cnt) status_cnt_drop <= '0;
      else if (rx_accept && !rx_legal && (status_cnt_drop != '1))
        status_cnt_drop <= status_cnt_drop + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state_q        <= TX_IDLE;
      md_tx_valid       <= 1'b0;
      md_tx_data        <= '0;
      md_tx_offset      <= '0;
      md_tx_size        <= '0;
      flush_pend_q      <= 1'b0;
      status_cnt_tx_err <= '0;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          if (tx_start) begin
            tx_state_q   <= TX_BUSY;
            md_tx_valid  <= 1'b1;
            md_tx_data   <= tx_start_data;
            md_tx_offset <= tx_start_off;
            md_tx_size   <= tx_start_size;
          end
        end
        TX_BUSY: begin
          if (md_tx_ready) begin
            tx_state_q   <= TX_GAP;
            md_tx_valid  <= 1'b0;
            md_tx_data   <= '0;
            md_tx_offset <= '0;
            md_tx_size   <= '0;
          end
        end
        TX_GAP:  tx_state_q <= TX_IDLE;
        default: tx_state_q <= TX_IDLE;
      endcase
      if (tx_tail_start)         flush_pend_q <= 1'b0;
      else if (flush)            flush_pend_q <= 1'b1;
      else if (buf_lvl == '0)    flush_pend_q <= 1'b0;
      if (clr_cnt) status_cnt_tx_err <= '0;
      else if (pop_en && md_tx_err && (status_cnt_tx_err != '1))
        status_cnt_tx_err <= status_cnt_tx_err + 8'd1;
    end
  end

endmodule
